scan_capture: RTL and testbench

- Receive-side counterpart of the LED-matrix scan driver.
- Watches the multiplexed row/column scan lines and rebuilds the full GS x GS frame bitmap.
- Uses the same enable/done handshake as the other pipeline stages: the controller raises the enable, the block answers with a done.
- Used for on-chip frame readback/self-check and for mirroring the display to a second matrix.

---
 rtl/scan_capture.sv | 115 +++++++++++
 tb/tb_scan_capture.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_capture.sv
// scan_capture: rebuilds a GS x GS frame bitmap from multiplexed row/column scan lines.
// Optional feature macro SCAN_CAPTURE_DIFF_EN adds changed_o (new frame differs from previous).
module scan_capture #(
    parameter int GS          = 8,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             e_cap_i,
    input  logic [GS-1:0]    row_val_i,
    input  logic [GS-1:0]    col_val_i,
    output logic [GS*GS-1:0] matrix_o,
    output logic             d_cap_o,
`ifdef SCAN_CAPTURE_DIFF_EN
    output logic             changed_o,
`endif
    output logic             err_o
);
    localparam int              TW     = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]      STB_TC = 8'(STABLE_CYC - 1);
    localparam logic [TW-1:0]   TMO_TC = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_DONE} state_t;

    state_t           state;
    logic [GS-1:0]    prev_row;
    logic [GS-1:0]    seen;
    logic [GS*GS-1:0] shadow;
    logic [7:0]       stb_cnt;
    logic [TW-1:0]    tmo_cnt;

    logic             one_hot;
    logic             multi;
    logic             hit;
    logic [7:0]       stb_nxt;
    logic [GS-1:0]    seen_nxt;
    logic [GS*GS-1:0] shadow_nxt;

    // Row qualification and the single-write-per-row shadow update.
    always_comb begin
        one_hot    = (row_val_i != '0) && ((row_val_i & (row_val_i - 1'b1)) == '0);
        multi      = (row_val_i != '0) && !one_hot;
        stb_nxt    = 8'd0;
        if (one_hot && (row_val_i == prev_row))
            stb_nxt = (stb_cnt == STB_TC) ? stb_cnt : stb_cnt + 8'd1;
        hit        = one_hot && (stb_nxt == STB_TC) && ((seen & row_val_i) == '0);
        seen_nxt   = hit ? (seen | row_val_i) : seen;
        shadow_nxt = shadow;
        for (int r = 0; r < GS; r++)
            if (hit && row_val_i[r]) shadow_nxt[r*GS +: GS] = col_val_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            prev_row <= '0;
            seen     <= '0;
            shadow   <= '0;
            stb_cnt  <= '0;
            tmo_cnt  <= '0;
            matrix_o <= '0;
            d_cap_o  <= 1'b0;
            err_o    <= 1'b0;
`ifdef SCAN_CAPTURE_DIFF_EN
            changed_o <= 1'b0;
`endif
        end else begin
            prev_row <= row_val_i;
            case (state)
                S_IDLE: begin
                    if (e_cap_i) begin
                        seen    <= '0;
                        shadow  <= '0;
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        err_o   <= 1'b0;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!e_cap_i) begin
                        state <= S_IDLE;
                    end else begin
                        stb_cnt <= stb_nxt;
                        seen    <= seen_nxt;
                        shadow  <= shadow_nxt;
                        if (tmo_cnt != TMO_TC) tmo_cnt <= tmo_cnt + 1'b1;
                        if (multi) err_o <= 1'b1;
                        // Completion outranks a timeout landing on the same cycle.
                        if (&seen_nxt) begin
                            matrix_o <= shadow_nxt;
                            d_cap_o  <= 1'b1;
                            state    <= S_DONE;
`ifdef SCAN_CAPTURE_DIFF_EN
                            changed_o <= (shadow_nxt != matrix_o);
`endif
                        end else if (tmo_cnt == TMO_TC) begin
                            err_o   <= 1'b1;
                            d_cap_o <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!e_cap_i) begin
                        d_cap_o <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_capture.sv
// Scoreboard bench for scan_capture: frames are described as row visits, a visit-level
// model predicts the captured frame, and a monitor checks it whenever d_cap_o rises.
module tb_scan_capture;
    localparam int GS          = 8;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             e_cap_i = 1'b0;
    logic [GS-1:0]    row_val_i = '0;
    logic [GS-1:0]    col_val_i = '0;
    logic [GS*GS-1:0] matrix_o;
    logic             d_cap_o;
    logic             err_o;
`ifdef SCAN_CAPTURE_DIFF_EN
    logic             changed_o;
`endif

    scan_capture #(.GS(GS), .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .e_cap_i   (e_cap_i),
        .row_val_i (row_val_i),
        .col_val_i (col_val_i),
        .matrix_o  (matrix_o),
        .d_cap_o   (d_cap_o),
`ifdef SCAN_CAPTURE_DIFF_EN
        .changed_o (changed_o),
`endif
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [GS-1:0] row;
        logic [GS-1:0] col;
        int            len;
        int            gap;
    } visit_t;

    typedef struct {
        logic [GS*GS-1:0] mat;
        logic             err;
        logic             chg;
        bit               chk_lat;
        int               done_cyc;
    } exp_t;

    visit_t           vq[$];
    exp_t             sbq[$];
    logic [GS*GS-1:0] held = '0;
    logic             last_chg = 1'b0;
    int               n_tests = 0;
    int               n_fail = 0;
    int               cyc = 0;
    bit               d_prev = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [GS*GS-1:0] act, input logic [GS*GS-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic int idx_of(input logic [GS-1:0] v);
        for (int i = 0; i < GS; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Monitor: one scoreboard entry per rising edge of d_cap_o.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n && d_cap_o === 1'b1 && !d_prev) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_matrix", matrix_o, e.mat);
                    chk("sb_err", err_o, e.err);
`ifdef SCAN_CAPTURE_DIFF_EN
                    chk("sb_changed", changed_o, e.chg);
`endif
                    if (e.chk_lat) chk("sb_latency", cyc, e.done_cyc);
                end
            end
            d_prev = d_cap_o;
        end
    end

    task automatic add_visit(input logic [GS-1:0] row, input logic [GS-1:0] col, input int len, input int gap);
        visit_t v;
        v.row = row; v.col = col; v.len = len; v.gap = gap;
        vq.push_back(v);
    endtask

    task automatic drive_seq(input logic [GS-1:0] row, input logic [GS-1:0] col, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk_i);
            row_val_i = row;
            col_val_i = col;
        end
    endtask

    task automatic wait_done(input int bound, input string nm);
        int k;
        k = 0;
        while (d_cap_o !== 1'b1 && k < bound) begin
            @(negedge clk_i);
            k++;
        end
        chk(nm, d_cap_o, 1'b1);
    endtask

    task automatic drop_enable();
        @(negedge clk_i);
        e_cap_i = 1'b0;
        @(negedge clk_i);
        chk("done_low_after_drop", d_cap_o, 1'b0);
    endtask

    // Model: a visit of a single row held >= STABLE_CYC cycles captures that row if not
    // yet captured; any multi-hot visit flags an error; all rows captured completes.
    task automatic run_frame(input bit hold_after);
        logic [GS*GS-1:0] fr;
        logic [GS-1:0]    seen;
        bit               er;
        int               done_idx, r;
        exp_t             e;
        fr = '0; seen = '0; er = 1'b0; done_idx = -1;
        foreach (vq[i]) begin
            if (done_idx < 0) begin
                if ($countones(vq[i].row) > 1) er = 1'b1;
                else if (vq[i].row != '0 && vq[i].len >= STABLE_CYC) begin
                    r = idx_of(vq[i].row);
                    if (!seen[r]) begin
                        fr[r*GS +: GS] = vq[i].col;
                        seen[r] = 1'b1;
                    end
                end
                if (&seen) done_idx = i;
            end
        end
        e.err = er;
        e.done_cyc = 0;
        if (done_idx >= 0) begin
            e.mat = fr; e.chg = (fr != held); e.chk_lat = 1'b1;
            held = fr; last_chg = e.chg;
        end else begin
            e.mat = held; e.err = 1'b1; e.chg = last_chg; e.chk_lat = 1'b0;
            sbq.push_back(e);
        end
        @(negedge clk_i);
        e_cap_i = 1'b1;
        row_val_i = '0;
        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].len; k++) begin
                @(negedge clk_i);
                row_val_i = vq[i].row;
                col_val_i = vq[i].col;
                if (i == done_idx && k == STABLE_CYC - 1) begin
                    e.done_cyc = cyc + 1;
                    sbq.push_back(e);
                    break;
                end
            end
            if (i == done_idx) break;
            for (int k = 0; k < vq[i].gap; k++) begin
                @(negedge clk_i);
                row_val_i = '0;
                col_val_i = GS'($urandom);
            end
        end
        wait_done((done_idx >= 0) ? 4 : TIMEOUT_CYC + 64, "frame_done");
        if (!hold_after) drop_enable();
    endtask

    task automatic clean_frame(input logic [GS-1:0] c0);
        vq.delete();
        for (int r = 0; r < GS; r++)
            add_visit(GS'(1) << r, (r == 0) ? c0 : ((r == GS - 1) ? 8'h81 : 8'h00), 6, 2);
    endtask

    task automatic gen_random();
        logic [GS-1:0] sn;
        logic [GS-1:0] rw;
        int            r, len;
        vq.delete();
        sn = '0;
        while (!(&sn) && vq.size() < 200) begin
            if ($urandom_range(9) == 0) begin
                rw = GS'(3) << $urandom_range(GS - 2);
                add_visit(rw, GS'($urandom), $urandom_range(1, 6), $urandom_range(1, 3));
            end else begin
                r = $urandom_range(GS - 1);
                len = $urandom_range(1, 7);
                if (len >= STABLE_CYC) sn[r] = 1'b1;
                add_visit(GS'(1) << r, GS'($urandom), len, $urandom_range(1, 3));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_matrix", matrix_o, '0);
        chk("rst_done", d_cap_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
`ifdef SCAN_CAPTURE_DIFF_EN
        chk("rst_changed", changed_o, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        // Clean frame, then hold enable high: no re-capture while in DONE
        clean_frame(8'h81);
        run_frame(1'b1);
        chk("clean_matrix", matrix_o, 64'h8100_0000_0000_0081);
        chk("clean_err", err_o, 1'b0);
        for (int r = 0; r < GS; r++) drive_seq(GS'(1) << r, 8'hFF, 6);
        chk("hold_done_high", d_cap_o, 1'b1);
        chk("hold_matrix", matrix_o, 64'h8100_0000_0000_0081);
        drop_enable();

        // Identical frame, then one flipped column bit
        clean_frame(8'h81);
        run_frame(1'b0);
        clean_frame(8'h83);
        run_frame(1'b0);
        chk("flip_matrix", matrix_o, 64'h8100_0000_0000_0083);

        // Glitch rejection: short row-3 visit carries different data
        vq.delete();
        add_visit(8'h08, 8'h5A, 3, 2);
        for (int r = 0; r < GS; r++) add_visit(GS'(1) << r, (r == 3) ? 8'hFF : GS'($urandom), 6, 2);
        run_frame(1'b0);
        chk("glitch_row3", matrix_o[31:24], 8'hFF);

        // Illegal multi-hot pattern mid-frame
        vq.delete();
        for (int r = 0; r < 4; r++) add_visit(GS'(1) << r, GS'($urandom), 6, 2);
        add_visit(8'h06, 8'hEE, 5, 2);
        for (int r = 4; r < GS; r++) add_visit(GS'(1) << r, GS'($urandom), 6, 2);
        run_frame(1'b0);

        // Timeout: rows 6 and 7 never appear
        vq.delete();
        for (int r = 0; r < 6; r++) add_visit(GS'(1) << r, 8'hC3, 6, 2);
        run_frame(1'b0);

        // Abort: enable dropped after 4 rows plus an illegal pattern
        @(negedge clk_i);
        e_cap_i = 1'b1;
        row_val_i = '0;
        for (int r = 0; r < 4; r++) begin
            drive_seq(GS'(1) << r, 8'h3C, 6);
            drive_seq('0, 8'h00, 2);
        end
        drive_seq(8'h18, 8'h00, 3);
        drive_seq('0, 8'h00, 1);
        e_cap_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_done", d_cap_o, 1'b0);
        chk("abort_matrix", matrix_o, held);
        chk("abort_err_kept", err_o, 1'b1);

        // Asynchronous reset mid-frame
        @(negedge clk_i);
        e_cap_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            drive_seq(GS'(1) << r, 8'h99, 6);
            drive_seq('0, 8'h00, 1);
        end
        drive_seq(8'hC0, 8'h00, 2);
        @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_matrix", matrix_o, '0);
        chk("arst_done", d_cap_o, 1'b0);
        chk("arst_err", err_o, 1'b0);
`ifdef SCAN_CAPTURE_DIFF_EN
        chk("arst_changed", changed_o, 1'b0);
`endif
        held = '0;
        last_chg = 1'b0;
        @(negedge clk_i);
        e_cap_i = 1'b0;
        row_val_i = '0;
        rst_n = 1'b1;
        @(negedge clk_i);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            gen_random();
            run_frame(1'b0);
        end

        repeat (4) @(negedge clk_i);
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
